// File: rtl/pixel_write_queue.sv
// Posted-write queue between the MCU register port and the SRAM memory manager.
// Clips off-screen pixels, acknowledges every accepted write, replays in order.
module pixel_write_queue #(
  parameter int DEPTH         = 8,
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 240
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [8:0] inXCoord,
  input  logic [7:0] inYCoord,
  input  logic [7:0] inWriteData,
  input  logic       inWriteRequest,
  output logic       inWriteComplete,
  output logic [8:0] memoryXCoord,
  output logic [7:0] memoryYCoord,
  output logic [7:0] memoryWriteData,
  output logic       memoryWriteRequest,
  input  logic       memoryWriteComplete,
  output logic       queueEmpty,
  output logic       queueFull,
  output logic [7:0] droppedCount
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [9:0] X_LIMIT = 10'(SCREEN_WIDTH);
  localparam logic [8:0] Y_LIMIT = 9'(SCREEN_HEIGHT);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [24:0]   store [DEPTH];
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] wrPtr;
  logic [AW:0]   count;
  logic [0:0]    state;

  logic onScreen;
  logic accept;
  logic push;
  logic pop;

  assign onScreen = ({1'b0, inXCoord} < X_LIMIT)
                 && ({1'b0, inYCoord} < Y_LIMIT);

  // The pending ack blocks a second accept while the MCU drops its request.
  assign accept = inWriteRequest && !inWriteComplete && !queueFull;
  assign push   = accept && onScreen;
  assign pop    = (state == BUSY) && memoryWriteComplete;

  assign queueEmpty = (count == '0);
  assign queueFull  = (count == FULL_COUNT);

  always_ff @(posedge clock) begin
    if (push) begin
      store[wrPtr] <= {inXCoord, inYCoord, inWriteData};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdPtr           <= '0;
      wrPtr           <= '0;
      count           <= '0;
      inWriteComplete <= 1'b0;
      droppedCount    <= 8'd0;
    end else begin
      inWriteComplete <= accept;
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (accept && !onScreen && droppedCount != 8'hFF) begin
        droppedCount <= droppedCount + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      memoryXCoord       <= 9'd0;
      memoryYCoord       <= 8'd0;
      memoryWriteData    <= 8'd0;
      memoryWriteRequest <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!queueEmpty) begin
            {memoryXCoord, memoryYCoord, memoryWriteData} <= store[rdPtr];
            memoryWriteRequest <= 1'b1;
            state              <= BUSY;
          end
        end
        BUSY: begin
          if (memoryWriteComplete) begin
            memoryWriteRequest <= 1'b0;
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_write_queue.sv
// Bench for pixel_write_queue: queue-based reference model, directed
// scenarios and a randomized MCU/memory-manager traffic phase.
module tb_pixel_write_queue;

  localparam int DEPTH = 8;

  typedef logic [24:0] entry_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [8:0] inXCoord = '0;
  logic [7:0] inYCoord = '0;
  logic [7:0] inWriteData = '0;
  logic       inWriteRequest = 1'b0;
  logic       inWriteComplete;
  logic [8:0] memoryXCoord;
  logic [7:0] memoryYCoord;
  logic [7:0] memoryWriteData;
  logic       memoryWriteRequest;
  logic       memoryWriteComplete = 1'b0;
  logic       queueEmpty;
  logic       queueFull;
  logic [7:0] droppedCount;

  pixel_write_queue #(
    .DEPTH(DEPTH), .SCREEN_WIDTH(320), .SCREEN_HEIGHT(240)
  ) dut (
    .clock(clock),
    .reset(reset),
    .inXCoord(inXCoord),
    .inYCoord(inYCoord),
    .inWriteData(inWriteData),
    .inWriteRequest(inWriteRequest),
    .inWriteComplete(inWriteComplete),
    .memoryXCoord(memoryXCoord),
    .memoryYCoord(memoryYCoord),
    .memoryWriteData(memoryWriteData),
    .memoryWriteRequest(memoryWriteRequest),
    .memoryWriteComplete(memoryWriteComplete),
    .queueEmpty(queueEmpty),
    .queueFull(queueFull),
    .droppedCount(droppedCount)
  );

  always #5 clock = ~clock;

  int nChecks = 0;
  int nFails  = 0;

  // reference model state
  entry_t mq[$];
  bit     mReq;
  bit     mAck;
  entry_t mHead;
  int     mDrop;

  // stimulus state
  entry_t pending[$];
  bit dnEnable, dnRandom, spurious, gapRandom, holdRandom;
  int dnDelay, age, holdAfter, holdLeft;

  // observations of the DUT
  entry_t issueLog[$];
  int     ackCount;
  bit     prevReq;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit onScreen(entry_t e);
    return (e[24:16] < 9'd320) && (e[15:8] < 8'd240);
  endfunction

  function automatic entry_t mk(int x, int y, int d);
    return {9'(x), 8'(y), 8'(d)};
  endfunction

  task automatic modelClear();
    mq.delete();
    mReq  = 0;
    mAck  = 0;
    mHead = '0;
    mDrop = 0;
  endtask

  task automatic modelEdge();
    entry_t e;
    bit acc;
    if (reset) begin
      modelClear();
      return;
    end
    e   = {inXCoord, inYCoord, inWriteData};
    acc = inWriteRequest && !mAck && (mq.size() < DEPTH);
    if (mReq) begin
      if (memoryWriteComplete) begin
        mReq = 0;
        void'(mq.pop_front());
      end
    end else if (mq.size() != 0) begin
      mReq  = 1;
      mHead = mq[0];
    end
    if (acc && onScreen(e)) mq.push_back(e);
    if (acc && !onScreen(e) && mDrop < 255) mDrop++;
    mAck = acc;
  endtask

  task automatic compareAll();
    check("inWriteComplete", inWriteComplete, mAck);
    check("memoryWriteRequest", memoryWriteRequest, mReq);
    if (mReq) begin
      check("memoryEntry",
            {memoryXCoord, memoryYCoord, memoryWriteData}, mHead);
    end
    check("queueEmpty", queueEmpty, mq.size() == 0);
    check("queueFull", queueFull, mq.size() == DEPTH);
    check("droppedCount", droppedCount, mDrop);
    if (memoryWriteRequest && !prevReq) begin
      issueLog.push_back({memoryXCoord, memoryYCoord, memoryWriteData});
    end
    prevReq = memoryWriteRequest;
    if (inWriteComplete) ackCount++;
  endtask

  task automatic step();
    @(posedge clock);
    modelEdge();
    @(negedge clock);
    compareAll();
  endtask

  task automatic dropRequest();
    inWriteRequest = 1'b0;
    void'(pending.pop_front());
    if (holdRandom) holdAfter = $urandom_range(0, 1);
  endtask

  task automatic drive();
    memoryWriteComplete = 1'b0;
    if (mReq) begin
      if (dnEnable) begin
        if (age >= dnDelay) begin
          memoryWriteComplete = 1'b1;
          age = 0;
          if (dnRandom) dnDelay = $urandom_range(0, 6);
        end else begin
          age++;
        end
      end
    end else begin
      age = 0;
      if (spurious && $urandom_range(0, 3) == 0) memoryWriteComplete = 1'b1;
    end
    if (inWriteRequest) begin
      if (mAck) begin
        if (holdAfter == 0) dropRequest();
        else holdLeft = holdAfter;
      end else if (holdLeft > 0) begin
        holdLeft--;
        if (holdLeft == 0) dropRequest();
      end
    end else if (pending.size() != 0
                 && (!gapRandom || $urandom_range(0, 2) == 0)) begin
      {inXCoord, inYCoord, inWriteData} = pending[0];
      inWriteRequest = 1'b1;
    end
  endtask

  task automatic cycle();
    step();
    drive();
  endtask

  task automatic settle(string tag, int budget);
    int n = 0;
    while ((pending.size() != 0 || inWriteRequest || mq.size() != 0 || mReq)
           && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_settled"},
          pending.size() + mq.size() + int'(inWriteRequest) + int'(mReq), 0);
  endtask

  task automatic resetDut();
    reset = 1'b1;
    inWriteRequest = 1'b0;
    memoryWriteComplete = 1'b0;
    pending.delete();
    holdLeft = 0;
    #1;
    modelClear();
    check("rst_memoryWriteRequest", memoryWriteRequest, 0);
    check("rst_queueEmpty", queueEmpty, 1);
    check("rst_droppedCount", droppedCount, 0);
    check("rst_inWriteComplete", inWriteComplete, 0);
    step();
    reset = 1'b0;
  endtask

  entry_t exp[$];
  entry_t got;
  int logBase, ackBase, nOut;

  initial begin
    dnEnable = 1; dnRandom = 0; spurious = 0; gapRandom = 0; holdRandom = 0;
    dnDelay = 3; age = 0; holdAfter = 1; holdLeft = 0;
    ackCount = 0; prevReq = 0;
    modelClear();

    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_mreq", memoryWriteRequest, 0);
    check("reset_mentry", {memoryXCoord, memoryYCoord, memoryWriteData}, 0);
    check("reset_ack", inWriteComplete, 0);
    check("reset_empty", queueEmpty, 1);
    check("reset_full", queueFull, 0);
    check("reset_dropped", droppedCount, 0);
    reset = 1'b0;

    // single write
    logBase = issueLog.size(); ackBase = ackCount;
    pending.push_back(mk(5, 2, 3));
    settle("t1", 60);
    repeat (3) cycle();
    check("t1_acks", ackCount - ackBase, 1);
    check("t1_issues", issueLog.size() - logBase, 1);
    got = (issueLog.size() > logBase) ? issueLog[logBase] : '1;
    check("t1_entry", got, mk(5, 2, 3));
    check("t1_empty", queueEmpty, 1);
    check("t1_mreq", memoryWriteRequest, 0);

    // fill past capacity with the memory manager stalled
    dnEnable = 0;
    logBase = issueLog.size(); ackBase = ackCount;
    for (int d = 0; d < 10; d++) pending.push_back(mk(10 + d, 20, d));
    repeat (30) cycle();
    check("t2_acks_stalled", ackCount - ackBase, 8);
    check("t2_full", queueFull, 1);
    dnEnable = 1;
    settle("t2", 300);
    check("t2_acks", ackCount - ackBase, 10);
    check("t2_issues", issueLog.size() - logBase, 10);
    for (int i = 0; i < 10; i++) begin
      got = (issueLog.size() > logBase + i) ? issueLog[logBase + i] : '1;
      check("t2_order", got, mk(10 + i, 20, i));
    end

    // off-screen clipping and saturation
    logBase = issueLog.size(); ackBase = ackCount;
    pending.push_back(mk(320, 0, 1));
    pending.push_back(mk(0, 240, 2));
    settle("t3a", 60);
    check("t3_acks", ackCount - ackBase, 2);
    check("t3_issues", issueLog.size() - logBase, 0);
    check("t3_dropped2", droppedCount, 2);
    for (int i = 0; i < 300; i++) begin
      pending.push_back((i % 2) ? mk(320 + (i % 100), 5, i) : mk(7, 240 + (i % 16), i));
    end
    settle("t3b", 3000);
    check("t3_dropped_sat", droppedCount, 255);
    check("t3_issues_sat", issueLog.size() - logBase, 0);

    // pop and push on the same edge with three entries queued
    dnEnable = 0;
    logBase = issueLog.size(); ackBase = ackCount;
    for (int d = 40; d < 43; d++) pending.push_back(mk(d, d, d));
    repeat (15) cycle();
    check("t4_mreq", memoryWriteRequest, 1);
    pending.push_back(mk(43, 43, 43));
    {inXCoord, inYCoord, inWriteData} = mk(43, 43, 43);
    inWriteRequest = 1'b1;
    memoryWriteComplete = 1'b1;
    cycle();
    check("t4_coincident_ack", inWriteComplete, 1);
    for (int d = 50; d < 56; d++) pending.push_back(mk(d, d, d));
    repeat (30) cycle();
    check("t4_acks_to_full", ackCount - ackBase, 9);
    check("t4_full", queueFull, 1);
    dnEnable = 1;
    settle("t4", 300);
    exp.delete();
    for (int d = 40; d < 44; d++) exp.push_back(mk(d, d, d));
    for (int d = 50; d < 56; d++) exp.push_back(mk(d, d, d));
    check("t4_issues", issueLog.size() - logBase, exp.size());
    foreach (exp[i]) begin
      got = (issueLog.size() > logBase + i) ? issueLog[logBase + i] : '1;
      check("t4_order", got, exp[i]);
    end

    // reset while busy
    dnEnable = 0;
    for (int d = 60; d < 64; d++) pending.push_back(mk(d, 1, d));
    repeat (15) cycle();
    check("t5_busy", memoryWriteRequest, 1);
    resetDut();
    dnEnable = 1;
    logBase = issueLog.size();
    pending.push_back(mk(1, 1, 7));
    settle("t5", 60);
    check("t5_issues", issueLog.size() - logBase, 1);
    got = (issueLog.size() > logBase) ? issueLog[logBase] : '1;
    check("t5_entry", got, mk(1, 1, 7));

    // MCU keeps its request up through the ack cycle
    holdAfter = 1;
    logBase = issueLog.size(); ackBase = ackCount;
    pending.push_back(mk(8, 9, 8'h66));
    settle("t6", 60);
    repeat (3) cycle();
    check("t6_acks", ackCount - ackBase, 1);
    check("t6_issues", issueLog.size() - logBase, 1);

    // randomized traffic
    dnRandom = 1; spurious = 1; gapRandom = 1; holdRandom = 1;
    logBase = issueLog.size(); ackBase = ackCount;
    exp.delete();
    nOut = 0;
    for (int i = 0; i < 400; i++) begin
      entry_t e;
      e[24:16] = ($urandom_range(0, 15) == 0) ? 9'($urandom_range(320, 511))
                                              : 9'($urandom_range(0, 319));
      e[15:8]  = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(240, 255))
                                              : 8'($urandom_range(0, 239));
      e[7:0]   = 8'($urandom);
      pending.push_back(e);
      if (onScreen(e)) exp.push_back(e);
      else nOut++;
    end
    settle("rand", 20000);
    spurious = 0;
    repeat (3) cycle();
    check("rand_acks", ackCount - ackBase, 400);
    check("rand_issues", issueLog.size() - logBase, exp.size());
    check("rand_dropped", droppedCount, (nOut > 255) ? 255 : nOut);
    foreach (exp[i]) begin
      got = (issueLog.size() > logBase + i) ? issueLog[logBase + i] : '1;
      check("rand_order", got, exp[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
